// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, iterative shift-add multiply
// and restoring divide, all results registered and flagged by a one-cycle done.
`timescale 1ns/1ps
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_b;

    logic             w_accept;
    logic             w_multi;
    logic             w_last;
    logic [WIDTH-1:0] w_alu_res;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_q_next;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_multi  = ALUControl[2] & ALUControl[1];
    assign w_last   = (r_state == S_CALC) && (r_cnt == CNT_W'(WIDTH - 1));
    assign busy     = (r_state == S_CALC);
    assign done     = (r_state == S_FIN);

    always_comb begin
        w_alu_res = '0;
        case (ALUControl)
            3'b000:  w_alu_res = srcA + srcB;
            3'b001:  w_alu_res = srcA - srcB;
            3'b010:  w_alu_res = srcA & srcB;
            3'b011:  w_alu_res = srcA | srcB;
            3'b100:  w_alu_res = srcA ^ srcB;
            3'b101:  w_alu_res = {{(WIDTH-1){1'b0}}, $signed(srcA) < $signed(srcB)};
            default: w_alu_res = '0;
        endcase
    end

    // Both iterations keep the low half / quotient in r_q and the high half /
    // remainder in r_acc, so the final write-back is identical for MUL and DIVU.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
        w_div_shift = {r_acc, r_q[WIDTH-1]};
        w_div_ok    = (w_div_shift >= {1'b0, r_b});
        w_div_diff  = w_div_shift - {1'b0, r_b};
        if (r_is_div) begin
            w_acc_next = w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
            w_q_next   = {r_q[WIDTH-2:0], w_div_ok};
        end else begin
            w_acc_next = w_mul_sum[WIDTH:1];
            w_q_next   = {w_mul_sum[0], r_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = w_multi ? S_CALC : S_FIN;
            S_CALC:  if (w_last) w_state_next = S_FIN;
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_q      <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            res      <= '0;
            hi       <= '0;
            zero     <= 1'b1;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= ALUControl[0];
            r_q      <= srcA;
            r_acc    <= '0;
            r_b      <= srcB;
            if (!w_multi) begin
                res  <= w_alu_res;
                hi   <= '0;
                zero <= (w_alu_res == '0);
            end
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + 1'b1;
            r_acc <= w_acc_next;
            r_q   <= w_q_next;
            if (w_last) begin
                res  <= w_q_next;
                hi   <= w_acc_next;
                zero <= (w_q_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] srcA;
    logic [W-1:0] srcB;
    logic [2:0]   ALUControl;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .srcA(srcA), .srcB(srcB),
        .ALUControl(ALUControl), .res(res), .hi(hi), .zero(zero),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [W-1:0] h);
        logic [2*W-1:0] p;
        r = '0;
        h = '0;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            3'd6: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r = p[W-1:0];
                h = p[2*W-1:W];
            end
            default: begin
                if (b == '0) begin
                    r = '1;
                    h = a;
                end else begin
                    r = a / b;
                    h = a % b;
                end
            end
        endcase
    endfunction

    // poke=1 raises start with junk operands while the op is still computing
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
        logic [W-1:0] er, eh;
        int  lat, nbusy, exp_lat, exp_busy;
        bit  got;
        model(op, a, b, er, eh);
        exp_lat  = (op >= 3'd6) ? W + 1 : 1;
        exp_busy = (op >= 3'd6) ? W : 0;
        @(negedge clk);
        start = 1'b1; ALUControl = op; srcA = a; srcB = b;
        @(posedge clk); #1;
        start = 1'b0; srcA = $urandom; srcB = $urandom; ALUControl = 3'($urandom);
        lat = 1; nbusy = 0; got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) nbusy++;
            start = (poke && k == 5) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, ".done_seen"}, 64'(got), 64'd1);
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".busy_cycles"}, 64'(nbusy), 64'(exp_busy));
        chk({tag, ".res"}, 64'(res), 64'(er));
        chk({tag, ".hi"}, 64'(hi), 64'(eh));
        chk({tag, ".zero"}, 64'(zero), 64'(er == '0));
        $display("op=%0d a=0x%08h b=0x%08h res=0x%08h hi=0x%08h zero=%0d lat=%0d [%s]",
                 op, a, b, res, hi, zero, lat, tag);
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, 64'(done), 64'd0);
        chk({tag, ".res_hold"}, 64'(res), 64'(er));
    endtask

    initial begin
        int ndone;
        logic [2:0]   op;
        logic [W-1:0] a, b;

        reset = 1'b1; start = 1'b1; ALUControl = 3'd0; srcA = 32'd5; srcB = 32'd6;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.res", 64'(res), 64'd0);
        chk("rst.hi", 64'(hi), 64'd0);
        chk("rst.zero", 64'(zero), 64'd1);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        @(negedge clk);
        start = 1'b0; reset = 1'b0;

        run_op("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op("slt_neg", 3'd5, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("slt_swap", 3'd5, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        run_op("sub", 3'd1, 32'h0000_0003, 32'h0000_0005, 1'b0);
        run_op("mul_max2", 3'd6, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        run_op("divu_100_7", 3'd7, 32'd100, 32'd7, 1'b0);
        run_op("divu_by0", 3'd7, 32'd5, 32'd0, 1'b0);
        run_op("mul_poke", 3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

        // reset lands in the middle of a divide: no done may follow
        @(negedge clk);
        start = 1'b1; ALUControl = 3'd7; srcA = 32'd1000; srcB = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rstmid.busy_before", 64'(busy), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rstmid.busy", 64'(busy), 64'd0);
        chk("rstmid.res", 64'(res), 64'd0);
        chk("rstmid.hi", 64'(hi), 64'd0);
        chk("rstmid.zero", 64'(zero), 64'd1);
        chk("rstmid.done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("rstmid.no_done", 64'(ndone), 64'd0);
        run_op("add_after_rst", 3'd0, 32'd3, 32'd4, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), op, a, b, ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
